mmio_dmem: RTL and testbench
============================

MMIO_DMEM -- requirements
Module: mmio_dmem

Interface
REQ-001 Parameter RAMWORDS, default 64, number of 32-bit data RAM words; power of two, 4..1024.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port we  input  1  store strobe from core M stage (memwriteM).
REQ-005 Port a  input  32  byte address from core M stage (aluoutM); bits [1:0] ignored.
REQ-006 Port wd  input  32  store data (writedataM).
REQ-007 Port rd  output  32  load data to core (readdataM), combinational from a and current state.
REQ-008 Port out_valid  output  1  output FIFO head word valid.
REQ-009 Port out_data  output  32  output FIFO head word.
REQ-010 Port out_ready  input  1  consumer accepts head word when high with out_valid.

Function
REQ-011 Address map SHALL be: RAM at 0x0000_0000 .. 4*RAMWORDS-4; CYCLE 0xFFFF_0000; FIFO 0xFFFF_0004; STATUS 0xFFFF_0008; DROP 0xFFFF_000C.
REQ-012 RAM SHALL use word index a[log2(RAMWORDS)+1:2]; write on clock edge when we=1; read combinational, same cycle.
REQ-013 Store and load to same RAM word in same cycle SHALL return old data on rd; new data visible next cycle.
REQ-014 CYCLE SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0; store loads wd (next-cycle value = wd, increments thereafter); load returns current value.
REQ-015 FIFO: 8 entries x 32 bits, circular read/write pointers, 4-bit count 0..8.
REQ-016 Store to FIFO address SHALL push wd when count<8; when count=8 and no pop same cycle, push dropped and DROP incremented.
REQ-017 Load from FIFO address SHALL return 0 and have no side effect.
REQ-018 out_valid SHALL equal (count!=0); out_data SHALL be entry at read pointer; pop when out_valid & out_ready.
REQ-019 Simultaneous push and pop SHALL both take effect: count unchanged; at count=8 push accepted (no drop).
REQ-020 No bypass: push into empty FIFO makes out_valid=1 the following cycle, not same cycle.
REQ-021 Pointers SHALL wrap 7 -> 0; FIFO order strictly first-in first-out.
REQ-022 STATUS read = {24'b0, count[3:0], 2'b0, empty, full}; full=(count==8), empty=(count==0); stores ignored.
REQ-023 DROP: 16-bit counter zero-extended on read, saturates at 0xFFFF; any store clears it to 0 (clear wins over simultaneous drop).
REQ-024 Unmapped address: rd=0, stores ignored, no state change.
REQ-025 we=0 SHALL cause no state change except CYCLE increment and FIFO pop.

Reset
REQ-026 On reset assertion, immediately and asynchronously: CYCLE=0, FIFO pointers and count=0, DROP=0, out_valid=0.
REQ-027 RAM contents SHALL be unaffected by reset.
REQ-028 Reset mid-operation SHALL discard FIFO contents; out_data value while out_valid=0 is don't-care.
REQ-029 First CYCLE increment SHALL occur on first rising edge after reset deasserts (value 1).

Verification
REQ-030 Store 0xDEADBEEF to 0x10, load 0x10 next cycle -> rd=0xDEADBEEF; load 0x10 same cycle as store -> prior value.
REQ-031 Reset, release, 5 edges, load 0xFFFF_0000 -> rd=5; store 0xFFFF_FFFE, 3 edges later read -> 0x0000_0001.
REQ-032 out_ready=0, push 1..9 to FIFO -> STATUS=0x81 after 8th push, DROP=1 after 9th; then out_ready=1 -> out_data 1..8 in order, then STATUS=0x02.
REQ-033 FIFO full, push 0xA5 with out_ready=1 same cycle -> DROP unchanged, count stays 8, 0xA5 emerges 8th.
REQ-034 Push into empty FIFO with out_ready=1 -> out_valid=0 that cycle, 1 next cycle, 0 after pop; reset with 3 entries -> out_valid=0 immediately, STATUS=0x02.
REQ-035 Load 0x0000_1000 and 0xFFFF_0010 -> rd=0; store there -> no RAM/peripheral change.

Source files
------------

// File: rtl/mmio_dmem.sv
// Data memory with memory-mapped peripherals: word RAM, free-running cycle counter,
// an 8-deep output FIFO with status and a saturating drop counter.
module mmio_dmem #(
  parameter int RAMWORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAMWORDS);

  logic [31:0]   ram [RAMWORDS];
  logic [31:0]   fifo_mem [8];

  logic [31:0]   cycle_q, cycle_d;
  logic [2:0]    wp_q, wp_d;
  logic [2:0]    rp_q, rp_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   drop_q, drop_d;

  logic          sel_ram, sel_cycle, sel_fifo, sel_status, sel_drop;
  logic [AW-1:0] widx;
  logic          fifo_full, fifo_empty;
  logic          push_req, push_ok, pop, drop_evt;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^a[1:0];

  assign sel_ram    = (a[31:AW+2] == '0);
  assign sel_cycle  = (a[31:2] == 30'h3FFF_C000);
  assign sel_fifo   = (a[31:2] == 30'h3FFF_C001);
  assign sel_status = (a[31:2] == 30'h3FFF_C002);
  assign sel_drop   = (a[31:2] == 30'h3FFF_C003);
  assign widx       = a[AW+1:2];

  assign fifo_full  = (cnt_q == 4'd8);
  assign fifo_empty = (cnt_q == 4'd0);
  assign pop        = !fifo_empty && out_ready;
  assign push_req   = we && sel_fifo;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop_evt   = push_req && fifo_full && !pop;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (we && sel_cycle) cycle_d = wd;
    wp_d  = push_ok ? wp_q + 3'd1 : wp_q;
    rp_d  = pop ? rp_q + 3'd1 : rp_q;
    cnt_d = cnt_q + {3'b000, push_ok} - {3'b000, pop};
    drop_d = drop_q;
    if (we && sel_drop)
      drop_d = 16'h0000;
    else if (drop_evt && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'd0;
      wp_q    <= 3'd0;
      rp_q    <= 3'd0;
      cnt_q   <= 4'd0;
      drop_q  <= 16'd0;
    end else begin
      cycle_q <= cycle_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Storage arrays carry no reset; only pointers and counters define validity.
  always_ff @(posedge clk) begin
    if (we && sel_ram) ram[widx] <= wd;
    if (push_ok) fifo_mem[wp_q] <= wd;
  end

  always_comb begin
    rd = 32'd0;
    if (sel_ram)         rd = ram[widx];
    else if (sel_cycle)  rd = cycle_q;
    else if (sel_status) rd = {24'd0, cnt_q, 2'b00, fifo_empty, fifo_full};
    else if (sel_drop)   rd = {16'd0, drop_q};
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_mem[rp_q];

endmodule

// File: tb/tb_mmio_dmem.sv
// Bench for mmio_dmem: directed scenarios plus randomized traffic against a
// queue/array reference model of the memory map.
module tb_mmio_dmem;

  localparam int RW = 64;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_FIFO = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_DROP = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] wd = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] rd;
  logic        out_valid;
  logic [31:0] out_data;

  mmio_dmem #(.RAMWORDS(RW)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] m_ram [RW];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle;
  int          m_drop;

  // 0 ram, 1 cycle, 2 fifo, 3 status, 4 drop, 5 unmapped
  function automatic int kind(input logic [31:0] ad);
    logic [31:0] w;
    w = {ad[31:2], 2'b00};
    if (w < 4 * RW) return 0;
    if (w == A_CYC)  return 1;
    if (w == A_FIFO) return 2;
    if (w == A_STAT) return 3;
    if (w == A_DROP) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] ad);
    logic [31:0] r;
    r = 32'd0;
    case (kind(ad))
      0: r = m_ram[int'(ad[31:2])];
      1: r = m_cycle;
      3: r = (m_q.size() * 16) + ((m_q.size() == 0) ? 2 : 0) + ((m_q.size() == 8) ? 1 : 0);
      4: r = 32'(m_drop);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_cycle = 32'd0;
    m_q.delete();
    m_drop = 0;
  endtask

  task automatic tick();
    int sz;
    int k;
    bit p;
    @(posedge clk);
    if (!reset) begin
      sz = m_q.size();
      k  = kind(a);
      p  = (sz != 0) && out_ready;
      if (p) void'(m_q.pop_front());
      if (we && k == 2) begin
        if (sz < 8 || p) m_q.push_back(wd);
        else if (m_drop < 65535) m_drop++;
      end
      if (we && k == 4) m_drop = 0;
      if (we && k == 1) m_cycle = wd;
      else m_cycle = m_cycle + 32'd1;
      if (we && k == 0) m_ram[int'(a[31:2])] = wd;
    end
    #1;
  endtask

  task automatic set_in(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic r);
    we = w; a = ad; wd = d; out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    we = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    set_in(0, A_STAT, 0, 0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (rd !== 32'h2) $display("FAIL reset_status: got %h want 00000002", rd); else n_pass++;
    set_in(0, A_CYC, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_cycle: got %h want 00000000", rd); else n_pass++;
    set_in(0, A_DROP, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_drop: got %h want 00000000", rd); else n_pass++;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < RW; i++) begin
      set_in(1, 32'(i * 4), $urandom, 0);
      tick();
    end
  endtask

  task automatic test_ram();
    logic [31:0] prior;
    prior = m_ram[4];
    if (prior == 32'hDEAD_BEEF) begin
      set_in(1, 32'h10, 32'h0BAD_F00D, 0);
      tick();
      prior = 32'h0BAD_F00D;
    end
    set_in(1, 32'h10, 32'hDEAD_BEEF, 0);
    n_total++; if (rd !== prior) $display("FAIL ram_same_cycle: got %h want %h", rd, prior); else n_pass++;
    tick();
    set_in(0, 32'h10, 0, 0);
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ram_next_cycle: got %h want deadbeef", rd); else n_pass++;
    set_in(0, 32'h13, 0, 0);
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ram_byte_offset: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_cycle();
    do_reset();
    set_in(0, A_CYC, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    n_total++; if (rd !== 32'd5) $display("FAIL cycle_after_reset: got %h want 00000005", rd); else n_pass++;
    set_in(1, A_CYC, 32'hFFFF_FFFE, 0);
    n_total++; if (rd !== 32'd5) $display("FAIL cycle_load_during_store: got %h want 00000005", rd); else n_pass++;
    tick();
    set_in(0, A_CYC, 0, 0);
    n_total++; if (rd !== 32'hFFFF_FFFE) $display("FAIL cycle_store: got %h want fffffffe", rd); else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_total++; if (rd !== 32'h1) $display("FAIL cycle_wrap: got %h want 00000001", rd); else n_pass++;
  endtask

  task automatic test_fifo_fill_drop();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      set_in(1, A_FIFO, 32'(i), 0);
      tick();
      if (i == 8) begin
        set_in(0, A_STAT, 0, 0);
        n_total++; if (rd !== 32'h81) $display("FAIL fill_status_full: got %h want 00000081", rd); else n_pass++;
      end
    end
    set_in(0, A_DROP, 0, 0);
    n_total++; if (rd !== 32'h1) $display("FAIL fill_drop: got %h want 00000001", rd); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      set_in(0, A_STAT, 0, 1);
      n_total++; if (out_valid !== 1'b1 || out_data !== 32'(i))
        $display("FAIL drain_order_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i)); else n_pass++;
      tick();
    end
    set_in(0, A_STAT, 0, 0);
    n_total++; if (rd !== 32'h2) $display("FAIL drain_status_empty: got %h want 00000002", rd); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, A_FIFO, 32'h100 + 32'(i), 0);
      tick();
    end
    set_in(1, A_FIFO, 32'hA5, 1);
    n_total++; if (out_data !== 32'h100) $display("FAIL full_pp_head: got %h want 00000100", out_data); else n_pass++;
    tick();
    set_in(0, A_STAT, 0, 0);
    n_total++; if (rd !== 32'h81) $display("FAIL full_pp_status: got %h want 00000081", rd); else n_pass++;
    set_in(0, A_DROP, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL full_pp_drop: got %h want 00000000", rd); else n_pass++;
    for (int j = 0; j < 8; j++) begin
      exp_v = (j < 7) ? 32'h101 + 32'(j) : 32'hA5;
      set_in(0, A_STAT, 0, 1);
      n_total++; if (out_valid !== 1'b1 || out_data !== exp_v)
        $display("FAIL full_pp_order_%0d: got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, exp_v); else n_pass++;
      tick();
    end
  endtask

  task automatic test_no_bypass_reset();
    do_reset();
    set_in(1, A_FIFO, 32'h77, 1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL nobypass_same: got %b want 0", out_valid); else n_pass++;
    tick();
    set_in(0, A_STAT, 0, 1);
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'h77)
      $display("FAIL nobypass_next: got v=%b d=%h want v=1 d=00000077", out_valid, out_data); else n_pass++;
    tick();
    set_in(0, A_STAT, 0, 0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL nobypass_popped: got %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      set_in(1, A_FIFO, $urandom, 0);
      tick();
    end
    set_in(0, A_STAT, 0, 0);
    n_total++; if (rd !== 32'h30) $display("FAIL three_status: got %h want 00000030", rd); else n_pass++;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (rd !== 32'h2) $display("FAIL async_reset_status: got %h want 00000002", rd); else n_pass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] ram0;
    logic [31:0] st;
    ram0 = m_ram[0];
    set_in(1, A_FIFO, 32'h55, 0);
    tick();
    set_in(0, 32'h0000_1000, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL unmapped_1000: got %h want 00000000", rd); else n_pass++;
    set_in(0, 32'hFFFF_0010, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL unmapped_ffff0010: got %h want 00000000", rd); else n_pass++;
    set_in(0, A_FIFO, 0, 0);
    n_total++; if (rd !== 32'h0) $display("FAIL fifo_load_zero: got %h want 00000000", rd); else n_pass++;
    set_in(1, 32'h0000_1000, 32'h1234_5678, 0);
    tick();
    set_in(1, 32'hFFFF_0010, 32'h9ABC_DEF0, 0);
    tick();
    set_in(1, A_STAT, 32'hFFFF_FFFF, 0);
    tick();
    set_in(0, 32'h0, 0, 0);
    n_total++; if (rd !== ram0) $display("FAIL unmapped_ram_intact: got %h want %h", rd, ram0); else n_pass++;
    st = m_rd(A_STAT);
    set_in(0, A_STAT, 0, 0);
    n_total++; if (rd !== st) $display("FAIL unmapped_status_intact: got %h want %h", rd, st); else n_pass++;
  endtask

  task automatic test_random();
    int          k;
    logic [31:0] ad;
    logic [31:0] exp_rd;
    for (int c = 0; c < 600; c++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: ad = 32'($urandom_range(0, RW - 1) * 4 + $urandom_range(0, 3));
        4:          ad = A_CYC;
        5, 6:       ad = A_FIFO;
        7:          ad = A_STAT;
        8:          ad = ($urandom_range(0, 3) == 0) ? A_DROP : A_FIFO;
        default:    ad = 32'h0001_0000 + 32'($urandom_range(0, 65535));
      endcase
      set_in(1'($urandom_range(0, 1)), ad, $urandom, ($urandom_range(0, 2) == 0));
      exp_rd = m_rd(ad);
      n_total++; if (rd !== exp_rd) $display("FAIL rand_rd_%0d: a=%h got %h want %h", c, ad, rd, exp_rd); else n_pass++;
      n_total++; if (out_valid !== (m_q.size() != 0))
        $display("FAIL rand_valid_%0d: got %b want %b", c, out_valid, (m_q.size() != 0)); else n_pass++;
      if (m_q.size() != 0) begin
        n_total++; if (out_data !== m_q[0]) $display("FAIL rand_data_%0d: got %h want %h", c, out_data, m_q[0]); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_fifo_fill_drop();
    test_full_push_pop();
    test_no_bypass_reset();
    test_unmapped();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
